// File: rtl/fetch_buffer.sv
// fetch_buffer: decoupling FIFO between the 4-wide fetch stage and decode.
//   Accepts up to PUSH_W instructions per cycle from fetch and presents the
//   POP_W oldest entries to decode in order. Decode reports how many entries it
//   consumed through pop_num. A flash from the control block clears everything.
//
// Ports
//   clk, rst    clock and synchronous active-high reset
//   flash       discard all entries (same-cycle push/pop ignored)
//   push_valid  per-lane fetch valid, lane 0 oldest; only leading ones accepted
//   push_data   lane i at [i*DATA_W +: DATA_W]  ({pc, inst})
//   push_ready  high when at least PUSH_W slots are free
//   out_valid   thermometer of visible entries, lane 0 = head
//   out_data    visible entries, lane 0 = head
//   pop_num     entries decode consumes this cycle (clamped to visible)
//   count       registered occupancy
//
// Configuration macro
//   FETCH_BUFFER_BYPASS_EN  when defined and the buffer is empty, accepted push
//                           lanes appear on the outputs in the same cycle.
module fetch_buffer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned PUSH_W = 4,
    parameter int unsigned POP_W  = 4,
    parameter int unsigned DATA_W = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flash,
    input  logic [PUSH_W-1:0]               push_valid,
    input  logic [PUSH_W*DATA_W-1:0]        push_data,
    output logic                            push_ready,
    output logic [POP_W-1:0]                out_valid,
    output logic [POP_W*DATA_W-1:0]         out_data,
    input  logic [$clog2(POP_W+1)-1:0]      pop_num,
    output logic [$clog2(DEPTH+1)-1:0]      count
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned PUSHN_W = $clog2(PUSH_W + 1);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic [PUSHN_W-1:0] w_n_lead;
    logic [PUSHN_W-1:0] w_n_push;
    logic [CNT_W-1:0]   w_n_vis;
    logic [CNT_W-1:0]   w_n_pop;
    logic [PUSH_W-1:0]  w_wr_en;
    logic               w_bypass;

    assign count = r_count;

    // Space check uses registered occupancy only; a same-cycle pop never frees room.
    assign push_ready = (CNT_W'(DEPTH) - r_count) >= CNT_W'(PUSH_W);

    // Count leading ones of push_valid; lanes after the first gap are dropped.
    always_comb begin
        w_n_lead = '0;
        for (int i = 0; i < PUSH_W; i++) begin
            if (push_valid[i] && (w_n_lead == PUSHN_W'(i))) begin
                w_n_lead = w_n_lead + PUSHN_W'(1);
            end
        end
    end

    assign w_n_push = push_ready ? w_n_lead : '0;

`ifdef FETCH_BUFFER_BYPASS_EN
    assign w_bypass = (r_count == '0) && !flash;
`else
    assign w_bypass = 1'b0;
`endif

    // Visible lanes: from storage, or mirrored push lanes when bypassing an empty buffer.
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        w_n_vis   = (r_count > CNT_W'(POP_W)) ? CNT_W'(POP_W) : r_count;
        for (int i = 0; i < POP_W; i++) begin
            out_valid[i]                 = CNT_W'(i) < r_count;
            out_data[i*DATA_W +: DATA_W] = r_mem[r_head + PTR_W'(i)];
        end
        if (w_bypass) begin
            w_n_vis = CNT_W'(w_n_push);
            for (int i = 0; i < POP_W; i++) begin
                if (i < PUSH_W) begin
                    out_valid[i]                 = PUSHN_W'(i) < w_n_push;
                    out_data[i*DATA_W +: DATA_W] = push_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Clamp the decode pop to what is actually visible.
    assign w_n_pop = (CNT_W'(pop_num) < w_n_vis) ? CNT_W'(pop_num) : w_n_vis;

    // Bypassed lanes that decode consumed are never written into storage.
    always_comb begin
        w_wr_en = '0;
        for (int i = 0; i < PUSH_W; i++) begin
            w_wr_en[i] = !flash && (PUSHN_W'(i) < w_n_push)
                         && !(w_bypass && (CNT_W'(i) < w_n_pop));
        end
    end

    // Storage array, not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PUSH_W; i++) begin
            if (w_wr_en[i]) begin
                r_mem[r_tail + PTR_W'(i)] <= push_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Pointer and occupancy update; reset beats flash.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flash) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_n_pop);
            r_tail  <= r_tail + PTR_W'(w_n_push);
            r_count <= r_count + CNT_W'(w_n_push) - w_n_pop;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

    logic         clk;
    logic         rst;
    logic         flash;
    logic [3:0]   push_valid;
    logic [255:0] push_data;
    logic         push_ready;
    logic [3:0]   out_valid;
    logic [255:0] out_data;
    logic [2:0]   pop_num;
    logic [4:0]   count;

    fetch_buffer #(.DEPTH(16), .PUSH_W(4), .POP_W(4), .DATA_W(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .flash      (flash),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .pop_num    (pop_num),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] sb_q[$];
    int          m_cnt = 0;
    logic [31:0] nxt_pc = 32'h0;
    logic [3:0]  exp_valid = 4'h0;
    logic        mon_en = 1'b0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] mk(input logic [31:0] pc);
        return {pc, pc ^ 32'hA5A5_0F0F};
    endfunction

    // Monitor: compares visible lanes against the scoreboard and retires consumed entries.
    always @(negedge clk) begin
        int vis;
        int np;
        if (mon_en && !rst) begin
            vis = $countones(exp_valid);
            chk("out_valid", {60'h0, out_valid}, {60'h0, exp_valid});
            for (int i = 0; i < vis; i++) begin
                if (i < sb_q.size()) begin
                    chk("lane_data", out_data[i*64 +: 64], sb_q[i]);
                end else begin
                    total++;
                    bad++;
                    $display("FAIL sb_underrun: lane %0d has no expected entry", i);
                end
            end
            np = flash ? 0 : ((int'(pop_num) < vis) ? int'(pop_num) : vis);
            for (int k = 0; k < np; k++) begin
                if (sb_q.size() > 0) void'(sb_q.pop_front());
            end
        end
    end

    // One clock of stimulus; expected entries are queued as they are issued.
    task automatic cyc(input logic [3:0] pv, input int pn, input logic fl);
        int ready;
        int nlead;
        int npush;
        int vis;
        int npop;
        push_valid = pv;
        pop_num    = 3'(pn);
        flash      = fl;
        for (int i = 0; i < 4; i++) push_data[i*64 +: 64] = mk(nxt_pc + 32'(4*i));
        ready = ((16 - m_cnt) >= 4) ? 1 : 0;
        nlead = 0;
        for (int i = 0; i < 4; i++) if (pv[i] && nlead == i) nlead++;
        npush = (ready != 0 && !fl) ? nlead : 0;
        for (int i = 0; i < npush; i++) sb_q.push_back(mk(nxt_pc + 32'(4*i)));
        vis = (m_cnt > 4) ? 4 : m_cnt;
`ifdef FETCH_BUFFER_BYPASS_EN
        if (m_cnt == 0 && !fl) vis = npush;
`endif
        exp_valid = 4'((1 << vis) - 1);
        npop = fl ? 0 : ((pn < vis) ? pn : vis);
        @(negedge clk);
        @(posedge clk);
        #1;
        m_cnt  = fl ? 0 : (m_cnt + npush - npop);
        nxt_pc = nxt_pc + 32'(4*npush);
        if (fl) sb_q.delete();
        chk("count", 64'(count), 64'(m_cnt));
        chk("push_ready", 64'(push_ready), ((16 - m_cnt) >= 4) ? 64'd1 : 64'd0);
        if (m_cnt > 16 || m_cnt < 0) begin
            total++;
            bad++;
            $display("FAIL occupancy_range: got %0d expected 0..16", m_cnt);
        end
    endtask

    initial begin
        rst        = 1'b1;
        flash      = 1'b0;
        push_valid = 4'hF;
        push_data  = '0;
        pop_num    = 3'd0;

        // Reset held two cycles with fetch asserting all lanes.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_push_ready", 64'(push_ready), 64'd1);
        mon_en = 1'b1;

        // Fill to 16, then a fifth push must be refused.
        for (int k = 0; k < 4; k++) cyc(4'hF, 0, 1'b0);
        chk("fill_count16", 64'(count), 64'd16);
        chk("fill_ready0", 64'(push_ready), 64'd0);
        cyc(4'hF, 0, 1'b0);
        chk("full_push_ignored", 64'(count), 64'd16);
        chk("next_pc_after_fill", 64'(nxt_pc), 64'h40);

        // Steady push with alternating pop 3 / pop 4 across pointer wrap.
        for (int k = 0; k < 20; k++) cyc(4'hF, (k % 2 == 0) ? 3 : 4, 1'b0);

        // Drain, bounded.
        for (int k = 0; k < 8 && m_cnt > 0; k++) cyc(4'h0, 4, 1'b0);
        chk("drained", 64'(count), 64'd0);

        // Clamp: pop 4 with only 2 present.
        cyc(4'b0011, 0, 1'b0);
        chk("clamp_pre", 64'(count), 64'd2);
        cyc(4'h0, 4, 1'b0);
        chk("clamp_post", 64'(count), 64'd0);

        // Contiguity: lane 3 behind a gap is dropped.
        cyc(4'b1011, 0, 1'b0);
        chk("contig_count", 64'(count), 64'd2);
        cyc(4'h0, 4, 1'b0);
        chk("contig_drained", 64'(count), 64'd0);

        // Flash at count 9 with push and pop in the same cycle.
        cyc(4'hF, 0, 1'b0);
        cyc(4'hF, 0, 1'b0);
        cyc(4'b0001, 0, 1'b0);
        chk("flash_pre", 64'(count), 64'd9);
        cyc(4'hF, 2, 1'b1);
        chk("flash_count", 64'(count), 64'd0);
        chk("flash_out_valid", 64'(out_valid), 64'd0);
        cyc(4'h0, 0, 1'b0);

        // Push into empty with full pop in the same cycle.
        nxt_pc = 32'h100;
        cyc(4'hF, 4, 1'b0);
`ifdef FETCH_BUFFER_BYPASS_EN
        chk("bypass_count", 64'(count), 64'd0);
`else
        chk("nobypass_count", 64'(count), 64'd4);
        cyc(4'h0, 4, 1'b0);
        chk("nobypass_drained", 64'(count), 64'd0);
`endif

        // Push into empty with partial pop.
        cyc(4'hF, 2, 1'b0);
`ifdef FETCH_BUFFER_BYPASS_EN
        chk("bypass_partial", 64'(count), 64'd2);
`else
        chk("nobypass_partial", 64'(count), 64'd4);
`endif
        for (int k = 0; k < 4 && m_cnt > 0; k++) cyc(4'h0, 4, 1'b0);
        chk("final_empty", 64'(count), 64'd0);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
